// File: rtl/seq_shift_add_multiplier.sv
// Iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, valid/ready on both sides.
// Optional macro SIGNED_MODE_EN adds a signed_mode port for two's-complement operands.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SIGNED_MODE_EN
    input  logic                 signed_mode,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    partial;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    mcand_ext;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             last;

`ifdef SIGNED_MODE_EN
    logic sgn;

    assign mcand_ext = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
`else
    assign mcand_ext = {{WIDTH{1'b0}}, a};
`endif

    assign last = (cnt == CW'(WIDTH - 1));

    // NOTE: acc_next gets a default before any branch so no latch is inferred.
    always_comb begin
        partial  = mcand << cnt;
        acc_next = acc;
        if (mplier[0]) begin
`ifdef SIGNED_MODE_EN
            // The multiplier MSB carries weight -2^(W-1) in two's complement.
            if (sgn && last) acc_next = acc - partial;
            else             acc_next = acc + partial;
`else
            acc_next = acc + partial;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
`ifdef SIGNED_MODE_EN
            sgn    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= mcand_ext;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
`ifdef SIGNED_MODE_EN
                        sgn    <= signed_mode;
`endif
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = out_valid ? acc : '0;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: WIDTH=4 and WIDTH=8 instances against a transaction-level model.
// With SIGNED_MODE_EN defined, signed corner products are exercised as well.
module tb_seq_shift_add_multiplier;

    typedef struct {
        bit          calc;
        bit          done;
        int          left;
        logic [63:0] prod;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv4 = 1'b0, ir4, ov4, ordy4 = 1'b1, busy4, sm4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  p4;

    logic        iv8 = 1'b0, ir8, ov8, ordy8 = 1'b1, busy8, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;

    int n_cmp = 0;
    int n_bad = 0;

    mdl_t m4 = '{calc: 1'b0, done: 1'b0, left: 0, prod: '0};
    mdl_t m8 = '{calc: 1'b0, done: 1'b0, left: 0, prod: '0};

    always #5 clk = ~clk;

    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
`ifdef SIGNED_MODE_EN
        .signed_mode(sm4),
`endif
        .out_valid(ov4), .out_ready(ordy4), .product(p4), .busy(busy4)
    );

    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
`ifdef SIGNED_MODE_EN
        .signed_mode(sm8),
`endif
        .out_valid(ov8), .out_ready(ordy8), .product(p8), .busy(busy8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Mathematical product of w-bit operands, reduced to 2w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input int w, input bit s);
        longint sx;
        longint sy;
        logic [63:0] mask;
        sx = longint'(x);
        sy = longint'(y);
        if (s && x[w-1]) sx -= (longint'(1) << w);
        if (s && y[w-1]) sy -= (longint'(1) << w);
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(sx * sy) & mask;
    endfunction

    // Transaction model: accept in idle, result ready W edges later, held until taken.
    function automatic mdl_t step(input mdl_t m, input bit iv, input bit ordy,
                                  input logic [63:0] p, input int w);
        mdl_t r = m;
        if (r.done) begin
            if (ordy) r.done = 1'b0;
        end else if (r.calc) begin
            r.left--;
            if (r.left == 0) begin
                r.calc = 1'b0;
                r.done = 1'b1;
            end
        end else if (iv) begin
            r.calc = 1'b1;
            r.left = w;
            r.prod = p;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4 = '{calc: 1'b0, done: 1'b0, left: 0, prod: '0};
            m8 = '{calc: 1'b0, done: 1'b0, left: 0, prod: '0};
        end else begin
            m4 = step(m4, iv4, ordy4, ref_mul(32'(a4), 32'(b4), 4, sm4), 4);
            m8 = step(m8, iv8, ordy8, ref_mul(32'(a8), 32'(b8), 8, sm8), 8);
        end
    end

    always @(negedge clk) begin
        check("ready4", 64'(ir4), 64'(!(m4.calc || m4.done)));
        check("valid4", 64'(ov4), 64'(m4.done));
        check("busy4",  64'(busy4), 64'(m4.calc || m4.done));
        if (m4.done) check("model_prod4", 64'(p4), m4.prod);
        check("ready8", 64'(ir8), 64'(!(m8.calc || m8.done)));
        check("valid8", 64'(ov8), 64'(m8.done));
        check("busy8",  64'(busy8), 64'(m8.calc || m8.done));
        if (m8.done) check("model_prod8", 64'(p8), m8.prod);
    end

    // Latency counts the accepting edge itself as edge 1, so out_valid is first seen after edge W+1.
    task automatic op4(input logic [3:0] x, input logic [3:0] y);
        int n;
        a4 = x; b4 = y; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        n = 1;
        while (!ov4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency4", 64'(n), 64'd5);
        check("prod4", 64'(p4), ref_mul(32'(x), 32'(y), 4, 1'b0));
        @(posedge clk); #1;
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input bit s,
                       input logic [15:0] exp, input int hold);
        int n;
        a8 = x; b8 = y; sm8 = s; iv8 = 1'b1;
        ordy8 = (hold == 0);
        @(posedge clk); #1;
        iv8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
        n = 1;
        while (!ov8 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency8", 64'(n), 64'd9);
        check("prod8", 64'(p8), 64'(exp));
        repeat (hold) begin
            @(posedge clk); #1;
        end
        ordy8 = 1'b1;
        @(posedge clk); #1;
        sm8 = 1'b0;
        check("idle_after8", 64'(ir8), 64'd1);
    endtask

    initial begin
        #12;
        check("rst_ready8", 64'(ir8), 64'd1);
        check("rst_valid8", 64'(ov8), 64'd0);
        check("rst_busy8",  64'(busy8), 64'd0);
        check("rst_prod8",  64'(p8), 64'd0);
        check("rst_prod4",  64'(p4), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                op4(4'(x), 4'(y));

        op8(8'd255, 8'd255, 1'b0, 16'hFE01, 0);
        op8(8'd0,   8'd200, 1'b0, 16'h0000, 0);
        op8(8'd1,   8'd173, 1'b0, 16'h00AD, 0);
        op8(8'd128, 8'd2,   1'b0, 16'h0100, 0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] x;
            logic [7:0] y;
            x = 8'($urandom);
            y = 8'($urandom);
            op8(x, y, 1'b0, 16'(ref_mul(32'(x), 32'(y), 8, 1'b0)), int'($urandom_range(0, 4)));
        end

        // Backpressure: hold the result for 20 cycles while in_valid pulses are ignored.
        a8 = 8'd12; b8 = 8'd13; iv8 = 1'b1; ordy8 = 1'b0;
        @(posedge clk); #1;
        iv8 = 1'b0;
        for (int k = 0; k < 20 && !ov8; k++) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 20; k++) begin
            check("bp_valid", 64'(ov8), 64'd1);
            check("bp_prod",  64'(p8), 64'h009C);
            check("bp_ready", 64'(ir8), 64'd0);
            iv8 = k[0];
            a8 = 8'($urandom); b8 = 8'($urandom);
            @(posedge clk); #1;
        end
        iv8 = 1'b0; ordy8 = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", 64'(ir8), 64'd1);
        check("bp_release_valid", 64'(ov8), 64'd0);

        // Reset in the middle of an operation.
        a8 = 8'd100; b8 = 8'd100; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(ov8), 64'd0);
        check("abort_prod",  64'(p8), 64'd0);
        check("abort_ready", 64'(ir8), 64'd1);
        check("abort_busy",  64'(busy8), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        op8(8'd7, 8'd9, 1'b0, 16'h003F, 0);

`ifdef SIGNED_MODE_EN
        op8(8'h80, 8'h80, 1'b1, 16'h4000, 0);
        op8(8'hFF, 8'h01, 1'b1, 16'hFFFF, 0);
        op8(8'h7F, 8'h80, 1'b1, 16'hC080, 0);
        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] x;
            logic [7:0] y;
            x = 8'($urandom);
            y = 8'($urandom);
            op8(x, y, 1'b1, 16'(ref_mul(32'(x), 32'(y), 8, 1'b1)), int'($urandom_range(0, 3)));
        end
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
